// File: rtl/teclado_cajero.sv
// teclado_cajero: keypad front end for the ATM core.
// Turns one-cycle key events into PIN digit strobes, a transaction type and a
// binary amount. It also follows the core's verdicts to sequence one card session.
module teclado_cajero #(
  parameter int PIN_LEN       = 4,
  parameter int MAX_DIG_MONTO = 9,
  parameter int ESPERA_CICLOS = 16
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic        TARJETA_RECIBIDA,
  input  logic [3:0]  TECLA,
  input  logic        TECLA_VALIDA,
  input  logic        PIN_INCORRECTO,
  input  logic        BLOQUEO,
  input  logic        BALANCE_ACTUALIZADO,
  input  logic        FONDOS_INSUFICIENTES,
  output logic [3:0]  DIGITO,
  output logic        DIGITO_STB,
  output logic        TIPO_TRANS,
  output logic [31:0] MONTO,
  output logic        MONTO_STB,
  output logic [3:0]  ESTADO,
  output logic        ERROR,
  output logic        LISTO
);

  // Counter widths sized from the parameters; the timer never needs to hold ESPERA_CICLOS itself.
  localparam int PW = $clog2(PIN_LEN + 1);
  localparam int CW = $clog2(MAX_DIG_MONTO + 1);
  localparam int TW = (ESPERA_CICLOS > 1) ? $clog2(ESPERA_CICLOS) : 1;

  localparam logic [PW-1:0] PIN_ULTIMO  = PW'(PIN_LEN - 1);
  localparam logic [CW-1:0] MONTO_LLENO = CW'(MAX_DIG_MONTO);
  localparam logic [TW-1:0] TIMER_FIN   = TW'(ESPERA_CICLOS - 1);

  // Key codes above 9.
  localparam logic [3:0] K_ENTER    = 4'hA;
  localparam logic [3:0] K_CANCEL   = 4'hB;
  localparam logic [3:0] K_DEPOSITO = 4'hC;
  localparam logic [3:0] K_RETIRO   = 4'hD;

  // The encoding is the externally visible ESTADO code.
  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_PIN        = 4'd1,
    ST_ESPERA_PIN = 4'd2,
    ST_TIPO       = 4'd3,
    ST_MONTO      = 4'd4,
    ST_ENVIAR     = 4'd5,
    ST_ESPERA_RES = 4'd6,
    ST_FIN        = 4'd7,
    ST_BLOQUEADO  = 4'd8
  } state_t;

  state_t        state;
  logic [PW-1:0] cnt_pin;
  logic [CW-1:0] cnt_monto;
  logic [TW-1:0] timer;

  logic        es_digito;
  logic        es_enter;
  logic        es_cancel;
  logic        es_deposito;
  logic        es_retiro;
  logic [31:0] monto_siguiente;

  // Key decode: only qualified events count; E/F decode to nothing and are ignored.
  assign es_digito   = TECLA_VALIDA && (TECLA <= 4'd9);
  assign es_enter    = TECLA_VALIDA && (TECLA == K_ENTER);
  assign es_cancel   = TECLA_VALIDA && (TECLA == K_CANCEL);
  assign es_deposito = TECLA_VALIDA && (TECLA == K_DEPOSITO);
  assign es_retiro   = TECLA_VALIDA && (TECLA == K_RETIRO);

  // Decimal accumulate without a multiplier: x*10 = x*8 + x*2.
  assign monto_siguiente = (MONTO << 3) + (MONTO << 1) + {28'd0, TECLA};

  assign ESTADO = state;
  assign LISTO  = (state == ST_FIN);

  // Session sequencer: one registered FSM producing every strobe and data output.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= ST_IDLE;
      DIGITO     <= '0;
      DIGITO_STB <= 1'b0;
      TIPO_TRANS <= 1'b0;
      MONTO      <= '0;
      MONTO_STB  <= 1'b0;
      ERROR      <= 1'b0;
      cnt_pin    <= '0;
      cnt_monto  <= '0;
      timer      <= '0;
    end else begin
      DIGITO_STB <= 1'b0;
      MONTO_STB  <= 1'b0;
      ERROR      <= 1'b0;
      if (!TARJETA_RECIBIDA) begin
        state      <= ST_IDLE;
        TIPO_TRANS <= 1'b0;
        MONTO      <= '0;
        cnt_pin    <= '0;
        cnt_monto  <= '0;
        timer      <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            state   <= ST_PIN;
            cnt_pin <= '0;
          end
          ST_PIN: begin
            if (BLOQUEO) begin
              state <= ST_BLOQUEADO;
            end else if (PIN_INCORRECTO || es_cancel) begin
              cnt_pin <= '0;
            end else if (es_digito && !DIGITO_STB) begin
              DIGITO     <= TECLA;
              DIGITO_STB <= 1'b1;
              cnt_pin    <= cnt_pin + PW'(1);
              if (cnt_pin == PIN_ULTIMO) begin
                state <= ST_ESPERA_PIN;
                timer <= '0;
              end
            end
          end
          ST_ESPERA_PIN: begin
            if (BLOQUEO) begin
              state <= ST_BLOQUEADO;
            end else if (PIN_INCORRECTO) begin
              state   <= ST_PIN;
              cnt_pin <= '0;
            end else if (timer == TIMER_FIN) begin
              state <= ST_TIPO;
            end else begin
              timer <= timer + TW'(1);
            end
          end
          ST_TIPO: begin
            if (es_deposito || es_retiro) begin
              TIPO_TRANS <= es_retiro;
              MONTO      <= '0;
              cnt_monto  <= '0;
              state      <= ST_MONTO;
            end else if (es_cancel) begin
              state <= ST_FIN;
            end
          end
          ST_MONTO: begin
            if (es_digito) begin
              if (cnt_monto == MONTO_LLENO) begin
                ERROR <= 1'b1;
              end else begin
                MONTO     <= monto_siguiente;
                cnt_monto <= cnt_monto + CW'(1);
              end
            end else if (es_enter) begin
              if (MONTO != 32'd0) begin
                MONTO_STB <= 1'b1;
                state     <= ST_ENVIAR;
              end else begin
                ERROR <= 1'b1;
              end
            end else if (es_cancel) begin
              MONTO     <= '0;
              cnt_monto <= '0;
            end
          end
          ST_ENVIAR: begin
            state <= ST_ESPERA_RES;
            timer <= '0;
          end
          ST_ESPERA_RES: begin
            if (BALANCE_ACTUALIZADO || FONDOS_INSUFICIENTES) begin
              state <= ST_FIN;
            end else if (timer == TIMER_FIN) begin
              ERROR <= 1'b1;
              state <= ST_FIN;
            end else begin
              timer <= timer + TW'(1);
            end
          end
          ST_FIN: begin
            state <= ST_FIN;
          end
          ST_BLOQUEADO: begin
            state <= ST_BLOQUEADO;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/teclado_cajero.md
Name: teclado_cajero

Overview:
- Keypad-side front end that drives the ATM core's transaction inputs.
- Converts one-cycle key events into per-digit PIN strobes (DIGITO/DIGITO_STB), a transaction type, and a binary amount (MONTO/MONTO_STB).
- Tracks the core's responses to sequence the session.
- Sits between the physical keypad decoder and the ATM core.

Parameters:
- PIN_LEN, 4: number of PIN digits forwarded before waiting for the verdict.
- MAX_DIG_MONTO, 9: maximum amount digits accepted (9 digits always fit in 32 bits).
- ESPERA_CICLOS, 16: response timeout in cycles, used in ESPERA_PIN and ESPERA_RES.

Ports:
- CLK  in  1  system clock, rising edge.
- RESET  in  1  synchronous, active-high reset.
- TARJETA_RECIBIDA  in  1  card present.
- TECLA  in  4  key code: 0-9 digits, A=ENTER, B=CANCEL, C=deposit, D=withdraw, E/F ignored.
- TECLA_VALIDA  in  1  one-cycle key event qualifier.
- PIN_INCORRECTO  in  1  from core.
- BLOQUEO  in  1  from core.
- BALANCE_ACTUALIZADO  in  1  from core.
- FONDOS_INSUFICIENTES  in  1  from core.
- DIGITO  out  4  PIN digit to core.
- DIGITO_STB  out  1  one-cycle digit strobe.
- TIPO_TRANS  out  1  0=deposit, 1=withdraw.
- MONTO  out  32  binary amount.
- MONTO_STB  out  1  one-cycle amount strobe.
- ESTADO  out  4  current state code.
- ERROR  out  1  one-cycle error pulse.
- LISTO  out  1  high while in FIN.

Behaviour:
- Reset (synchronous, active-high, dominates everything): state IDLE; all outputs 0; MONTO=0; digit counters 0; timeout counter 0.
- Card removal: TARJETA_RECIBIDA=0 in any state forces IDLE on the next edge and clears MONTO, TIPO_TRANS and counters. It overrides any key event in the same cycle.
- Key handling: only keys with TECLA_VALIDA=1 act. Codes E/F and keys invalid for the current state are ignored, with no ERROR.
- State codes:
  - IDLE (0): TARJETA_RECIBIDA=1 -> PIN.
  - PIN (1): each digit key produces DIGITO=key and DIGITO_STB=1 on the next cycle (latency 1) and increments cnt_pin.
    - When cnt_pin reaches PIN_LEN -> ESPERA_PIN, timer cleared.
    - PIN_INCORRECTO=1 sampled here -> cnt_pin=0.
    - CANCEL -> cnt_pin=0, no strobe.
    - BLOQUEO=1 -> BLOQUEADO.
  - ESPERA_PIN (2): the timer counts each cycle. Priority: BLOQUEO -> BLOQUEADO; PIN_INCORRECTO -> PIN with cnt_pin=0; timer==ESPERA_CICLOS-1 -> TIPO.
  - TIPO (3): C -> TIPO_TRANS=0, MONTO -> amount entry. D -> TIPO_TRANS=1, amount entry. CANCEL -> FIN.
  - MONTO (4): on a digit key, MONTO <= MONTO*10 + key and cnt_monto increments.
    - Digit when cnt_monto==MAX_DIG_MONTO -> ignored, ERROR pulse.
    - ENTER with MONTO!=0 -> ENVIAR. ENTER with MONTO==0 -> ERROR pulse, stay.
    - CANCEL -> MONTO=0, cnt_monto=0, stay.
  - ENVIAR (5): MONTO_STB=1 for exactly one cycle, MONTO held stable -> ESPERA_RES, timer cleared.
  - ESPERA_RES (6): BALANCE_ACTUALIZADO or FONDOS_INSUFICIENTES -> FIN. Timeout -> ERROR pulse, FIN.
  - FIN (7): LISTO=1. MONTO and TIPO_TRANS hold. Leaves only on card removal.
  - BLOQUEADO (8): all strobes 0, keys ignored. Leaves only on card removal or RESET.
- Output rules: DIGITO_STB and MONTO_STB never high in the same cycle and never high for two consecutive cycles. DIGITO holds its last value between strobes.
- Arithmetic: MONTO*10 computed as (MONTO<<3)+(MONTO<<1) in 32 bits. Overflow cannot occur under the MAX_DIG_MONTO limit.

Test Plan:
- Reset then card in, keys 6,7,6,7 -> four DIGITO_STB pulses each 1 cycle after its key, DIGITO=6,7,6,7. ESTADO goes 1 -> 2, then 3 after 16 cycles with no PIN_INCORRECTO.
- In ESPERA_PIN drive PIN_INCORRECTO=1 for 1 cycle -> ESTADO=1, cnt_pin=0. Then hold BLOQUEO=1 -> ESTADO=8, and later keys 1,2 produce no strobes.
- After PIN accepted: keys D,1,5,0,0,0,ENTER -> TIPO_TRANS=1, MONTO=15000 (0x3A98), a single MONTO_STB, ESTADO=6. Then FONDOS_INSUFICIENTES=1 -> ESTADO=7, LISTO=1.
- In MONTO state: ten 9-digit keys -> MONTO=999999999, ERROR pulse on the 10th key. CANCEL -> MONTO=0. ENTER at 0 -> ERROR pulse, ESTADO stays 4.
- In ESPERA_RES with no response for 16 cycles -> ERROR pulse, ESTADO=7.
- Drop TARJETA_RECIBIDA mid-amount in the same cycle as a digit key -> ESTADO=0, MONTO=0, no strobe. Assert RESET in ENVIAR -> MONTO_STB=0 the next cycle, ESTADO=0.
